wvfm_loader: RTL and testbench

- Writer side of the waveform lookup table's write port (we/addr/din).
- Accepts a byte stream from the host command path (valid/ready) and writes it sequentially into the LUT from a programmed base address.
- Writes happen only while the display pipeline grants the port (wr_allow, e.g. vertical blanking), because a write overrides read port A's address.
- Validates the payload against a trailing 8-bit checksum byte and reports done/error.

---
 rtl/wvfm_loader_if.sv | 37 +++
 rtl/wvfm_loader.sv | 167 ++++++++++++++++
 tb/tb_wvfm_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wvfm_loader_if.sv
// wvfm_loader_if: groups the host byte stream (valid/ready) and the LUT
// write port (we/addr/din), together with the write-port grant, into one
// bundle.
//
//   in_valid  host -> loader   stream byte valid
//   in_data   host -> loader   stream byte
//   in_ready  loader -> host   loader accepts in_data this cycle
//   wr_allow  pipe -> loader   LUT write port granted this cycle
//   we        loader -> LUT    write enable
//   addr      loader -> LUT    write address
//   din       loader -> LUT    write data
//
// Modports:
//   master  host/LUT side (drives stream and grant, observes writes)
//   slave   loader side
interface wvfm_loader_if #(
    parameter int ABITS = 12,
    parameter int DBITS = 8
);
    logic             in_valid;
    logic [DBITS-1:0] in_data;
    logic             in_ready;
    logic             wr_allow;
    logic             we;
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] din;

    modport master (
        output in_valid, in_data, wr_allow,
        input  in_ready, we, addr, din
    );

    modport slave (
        input  in_valid, in_data, wr_allow,
        output in_ready, we, addr, din
    );
endinterface

// File: rtl/wvfm_loader.sv
// wvfm_loader: writer side of the waveform LUT write port.
//
// Accepts a byte stream and writes it sequentially into the LUT starting at
// a programmed base address (wrapping modulo 2^ABITS). Payload bytes are
// only accepted while the display pipeline grants the write port. A
// trailing checksum byte is compared against the modular sum of the payload.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse; begins a load (only honoured in IDLE)
//   base_addr  first LUT address, sampled on an accepted start
//   length     payload byte count 0..2^ABITS, sampled on an accepted start
//   abort      cancels a load in progress
//   lut        stream + LUT write port bundle (slave side)
//   busy       FSM not in IDLE
//   done       one-cycle pulse at load completion or abort
//   err        checksum mismatch or abort; held until the next accepted start
//   sum        running modular sum of the payload bytes
module wvfm_loader #(
    parameter int ABITS = 12,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ABITS-1:0] base_addr,
    input  logic [ABITS:0]   length,
    input  logic             abort,
    wvfm_loader_if.slave     lut,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [DBITS-1:0] sum
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ABITS-1:0] base_q;
    logic [ABITS:0]   len_q;
    logic [ABITS:0]   count;
    logic [ABITS:0]   count_inc;
    logic             in_ready_c;
    logic             xfer;
    logic             start_ok;
    logic             load_xfer;
    logic             check_xfer;
    logic             abort_ok;
    logic             we_q;
    logic [ABITS-1:0] addr_q;
    logic [DBITS-1:0] din_q;

    // Abort has priority over a transfer: ready is masked while abort is high,
    // so an abort-cycle byte is never taken.
    always_comb begin
        in_ready_c = 1'b0;
        case (state)
            ST_LOAD:  in_ready_c = lut.wr_allow;
            ST_CHECK: in_ready_c = 1'b1;
            default:  in_ready_c = 1'b0;
        endcase
        if (abort) begin
            in_ready_c = 1'b0;
        end
    end

    assign lut.in_ready = in_ready_c;
    assign lut.we       = we_q;
    assign lut.addr     = addr_q;
    assign lut.din      = din_q;

    assign xfer       = lut.in_valid & in_ready_c;
    assign start_ok   = start & (state == ST_IDLE);
    assign load_xfer  = xfer & (state == ST_LOAD);
    assign check_xfer = xfer & (state == ST_CHECK);
    assign abort_ok   = abort & ((state == ST_LOAD) | (state == ST_CHECK));
    assign count_inc  = count + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? ST_CHECK : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (load_xfer && (count_inc == len_q)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort || check_xfer) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // busy and done are registered from the next state so they line up
    // with the state register rather than trailing it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            done  <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            count  <= '0;
            sum    <= '0;
            err    <= 1'b0;
        end else begin
            if (start_ok) begin
                base_q <= base_addr;
                len_q  <= length;
                count  <= '0;
                sum    <= '0;
                err    <= 1'b0;
            end
            if (load_xfer) begin
                sum   <= sum + lut.in_data;
                count <= count_inc;
            end
            if (check_xfer) begin
                err <= (lut.in_data != sum);
            end
            if (abort_ok) begin
                err <= 1'b1;
            end
        end
    end

    // LUT write port: a payload transfer is written on the following cycle.
    // The address uses the pre-increment count; dropping the count MSB gives
    // the modulo-2^ABITS wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            we_q <= load_xfer;
            if (load_xfer) begin
                addr_q <= base_q + count[ABITS-1:0];
                din_q  <= lut.in_data;
            end
        end
    end

endmodule

// File: tb/tb_wvfm_loader.sv
// tb_wvfm_loader: scoreboard bench for wvfm_loader. Each accepted payload
// byte pushes its expected LUT write (address, data, cycle); a monitor on
// the falling edge pops and compares every write and flags any stray one.
module tb_wvfm_loader;

    localparam int ABITS = 12;
    localparam int DBITS = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [ABITS-1:0] base_addr;
    logic [ABITS:0]   length;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [DBITS-1:0] sum;

    wvfm_loader_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

    wvfm_loader #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .lut       (bus.slave),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sum       (sum)
    );

    typedef struct {
        logic [ABITS-1:0] a;
        logic [DBITS-1:0] d;
        int               c;
    } wr_t;

    wr_t              sb[$];
    wr_t              mon_e;
    logic [DBITS-1:0] pl[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               wr_seen  = 0;
    int               stall_ph = 0;
    logic [DBITS-1:0] model_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Write monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].c <= cyc) begin
                mon_e = sb.pop_front();
                check("we", {31'd0, bus.we}, 32'd1);
                check("addr", {20'd0, bus.addr}, {20'd0, mon_e.a});
                check("din", {24'd0, bus.din}, {24'd0, mon_e.d});
            end else begin
                check("we_idle", {31'd0, bus.we}, 32'd0);
            end
            if (bus.we) wr_seen++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [DBITS-1:0] d, input bit is_chk,
                             input logic [ABITS-1:0] a, input bit stall);
        int guard;
        logic exp_rdy;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            if (stall) begin
                bus.wr_allow = (stall_ph % 3 == 0);
                stall_ph++;
            end
            #1;
            exp_rdy = is_chk ? 1'b1 : bus.wr_allow;
            if (stall) check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            if (bus.in_ready) break;
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                check("rdy_timeout", {31'd0, bus.in_ready}, 32'd1);
                return;
            end
        end
        if (!is_chk) begin
            sb.push_back('{a: a, d: d, c: cyc + 1});
            model_sum = model_sum + d;
        end
        @(negedge clk);
    endtask

    task automatic do_start(input logic [ABITS-1:0] b, input logic [ABITS:0] len);
        start     = 1'b1;
        base_addr = b;
        length    = len;
        @(negedge clk);
        start     = 1'b0;
        check("busy_start", {31'd0, busy}, 32'd1);
        model_sum = '0;
    endtask

    task automatic do_load(input logic [ABITS-1:0] b, input logic [ABITS:0] len,
                           input logic [DBITS-1:0] chk, input bit stall, input bit exp_err);
        do_start(b, len);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl[i], 1'b0, b + ABITS'(i), stall);
        end
        if (stall) bus.wr_allow = 1'b0;
        send_byte(chk, 1'b1, '0, 1'b0);
        bus.in_valid = 1'b0;
        bus.wr_allow = 1'b1;
        check("done", {31'd0, done}, 32'd1);
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("sum", {24'd0, sum}, {24'd0, model_sum});
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("err_hold", {31'd0, err}, {31'd0, exp_err});
        check("sum_hold", {24'd0, sum}, {24'd0, model_sum});
        check("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        length       = '0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.wr_allow = 1'b1;
        model_sum    = '0;
        #2;
        check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_we", {31'd0, bus.we}, 32'd0);
        check("rst_addr", {20'd0, bus.addr}, 32'd0);
        check("rst_din", {24'd0, bus.din}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load and bad checksum
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(12'h010, 13'd4, 8'h0A, 1'b0, 1'b0);
        do_load(12'h010, 13'd4, 8'h0B, 1'b0, 1'b1);

        // Stall with address wrap
        pl = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        stall_ph = 0;
        do_load(12'hFFE, 13'd4, 8'hE6, 1'b1, 1'b0);

        // Zero length
        do_load(12'h123, 13'd0, 8'h00, 1'b0, 1'b0);
        do_load(12'h123, 13'd0, 8'h05, 1'b0, 1'b1);

        // Abort after 2 of 8 bytes; a start mid-load must be ignored
        pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        wr_seen = 0;
        do_start(12'h100, 13'd8);
        send_byte(pl[0], 1'b0, 12'h100, 1'b0);
        start     = 1'b1;
        base_addr = 12'h555;
        length    = 13'd1;
        send_byte(pl[1], 1'b0, 12'h101, 1'b0);
        start        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = pl[2];
        abort        = 1'b1;
        #1;
        check("abort_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_done", {31'd0, done}, 32'd1);
        check("abort_err", {31'd0, err}, 32'd1);
        check("abort_sum", {24'd0, sum}, 32'h21);
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done_pulse", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("abort_writes", wr_seen, 32'd2);
        check("abort_sb_empty", sb.size(), 32'd0);

        // Full LUT: every address once, including the 2^ABITS boundary
        pl.delete();
        model_sum = '0;
        for (int i = 0; i < 4096; i++) begin
            pl.push_back(DBITS'(i * 13 + 5));
            model_sum = model_sum + DBITS'(i * 13 + 5);
        end
        wr_seen = 0;
        begin
            logic [DBITS-1:0] full_chk;
            full_chk = model_sum;
            do_load(12'h800, 13'd4096, full_chk, 1'b0, 1'b0);
        end
        check("full_writes", wr_seen, 32'd4096);

        // Async reset mid-load
        pl = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        do_start(12'h200, 13'd4);
        send_byte(pl[0], 1'b0, 12'h200, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = pl[1];
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'd0, bus.we}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, bus.in_ready}, 32'd0);
        check("arst_sum", {24'd0, sum}, 32'd0);
        sb.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pl = '{8'h11, 8'h22};
        do_load(12'h300, 13'd2, 8'h33, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
